// File: rtl/rom_port_arbiter_pkg.sv
// Shared types and constants for the program-ROM port arbiter.
// ROM_AW/ROM_DW are also used by the CPU fetch stage and the ROM itself.
package rom_port_arbiter_pkg;

   localparam int ROM_AW  = 8;
   localparam int ROM_DW  = 35;
   localparam int STALL_W = 4;

   // A burst length field of zero requests the full 2^AW words.
   localparam bit LEN_ZERO_IS_256 = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rom_port_arbiter_if.sv
// Bus bundle between the requesters (CPU fetch, debug reader), the ROM and the arbiter.
interface rom_port_arbiter_if
   import rom_port_arbiter_pkg::*;
#(
   parameter int AW = ROM_AW,
   parameter int DW = ROM_DW
);

   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic          cpu_gnt;
   logic          cpu_valid;
   logic [DW-1:0] cpu_data;

   logic          dbg_start;
   logic [AW-1:0] dbg_base;
   logic [AW-1:0] dbg_len;
   logic          dbg_busy;
   logic          dbg_valid;
   logic [DW-1:0] dbg_data;
   logic [AW-1:0] dbg_addr_out;
   logic          dbg_done;
   logic [DW-1:0] dbg_sum;

   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data;

   modport slave (
      input  cpu_req, cpu_addr, dbg_start, dbg_base, dbg_len, rom_data,
      output cpu_gnt, cpu_valid, cpu_data, dbg_busy, dbg_valid, dbg_data,
             dbg_addr_out, dbg_done, dbg_sum, rom_addr
   );

   modport master (
      output cpu_req, cpu_addr, dbg_start, dbg_base, dbg_len, rom_data,
      input  cpu_gnt, cpu_valid, cpu_data, dbg_busy, dbg_valid, dbg_data,
             dbg_addr_out, dbg_done, dbg_sum, rom_addr
   );

endinterface

// File: rtl/rom_arb_stall_ctr.sv
// Saturating count of consecutive debug denials; force_slot hands the next slot to debug.
module rom_arb_stall_ctr
   import rom_port_arbiter_pkg::*;
#(
   parameter int MAX_STALL = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic force_slot
);

   localparam logic [STALL_W-1:0] MAX_C = STALL_W'(MAX_STALL);

   logic [STALL_W-1:0] stall;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall <= '0;
      end else if (clr) begin
         stall <= '0;
      end else if (inc && (stall != MAX_C)) begin
         stall <= stall + STALL_W'(1);
      end
   end

   assign force_slot = (stall == MAX_C);

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one asynchronous program ROM between CPU fetch (priority) and a debug burst reader.
// Optional burst XOR checksum on dbg_sum is built when ROM_ARB_SUM_EN is defined.
module rom_port_arbiter
   import rom_port_arbiter_pkg::*;
#(
   parameter int AW        = ROM_AW,
   parameter int DW        = ROM_DW,
   parameter int MAX_STALL = 4
) (
   input  logic               clk,
   input  logic               reset,
   rom_port_arbiter_if.slave  bus
);

   // Remaining count carries one extra bit so a full 2^AW burst fits.
   localparam int RW = AW + 1;

   arb_state_e     state;
   logic [AW-1:0]  ptr;
   logic [RW-1:0]  rem;
   logic           busy;

   logic           dbg_req;
   logic           dbg_gnt;
   logic           cpu_gnt;
   logic           force_slot;
   logic           start_ok;
   logic           last_word;
   logic           stall_inc;

   logic           cpu_vld_p1;
   logic [DW-1:0]  cpu_data_p1;
   logic           dbg_vld_p1;
   logic [DW-1:0]  dbg_data_p1;
   logic [AW-1:0]  dbg_addr_p1;
   logic           dbg_done_p1;

   function automatic logic [RW-1:0] burst_words(input logic [AW-1:0] len);
      if (LEN_ZERO_IS_256 && (len == '0)) begin
         return RW'(1) << AW;
      end
      return {1'b0, len};
   endfunction

   // Grant decision (stage p0, combinational)
   assign dbg_req   = (state == BURST);
   assign dbg_gnt   = dbg_req & (~bus.cpu_req | force_slot);
   assign cpu_gnt   = bus.cpu_req & ~dbg_gnt;
   assign start_ok  = (state == IDLE) & bus.dbg_start;
   assign last_word = dbg_gnt & (rem == RW'(1));
   assign stall_inc = dbg_req & bus.cpu_req & ~force_slot;

   assign bus.cpu_gnt  = cpu_gnt;
   assign bus.rom_addr = (!cpu_gnt && dbg_gnt) ? ptr : bus.cpu_addr;

   rom_arb_stall_ctr #(
      .MAX_STALL (MAX_STALL)
   ) u_stall_ctr (
      .clk        (clk),
      .reset      (reset),
      .clr        (start_ok | dbg_gnt),
      .inc        (stall_inc),
      .force_slot (force_slot)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
         rem   <= '0;
         busy  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_ok) begin
                  ptr   <= bus.dbg_base;
                  rem   <= burst_words(bus.dbg_len);
                  state <= BURST;
                  busy  <= 1'b1;
               end
            end
            BURST: begin
               if (dbg_gnt) begin
                  ptr <= ptr + AW'(1);
                  rem <= rem - RW'(1);
                  if (rem == RW'(1)) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Stage p0 -> p1: capture the ROM word at the end of the grant cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         cpu_vld_p1  <= 1'b0;
         cpu_data_p1 <= '0;
         dbg_vld_p1  <= 1'b0;
         dbg_data_p1 <= '0;
         dbg_addr_p1 <= '0;
         dbg_done_p1 <= 1'b0;
      end else begin
         cpu_vld_p1  <= cpu_gnt;
         dbg_vld_p1  <= dbg_gnt;
         dbg_done_p1 <= last_word;
         if (cpu_gnt) begin
            cpu_data_p1 <= bus.rom_data;
         end
         if (dbg_gnt) begin
            dbg_data_p1 <= bus.rom_data;
            dbg_addr_p1 <= ptr;
         end
      end
   end

   assign bus.cpu_valid    = cpu_vld_p1;
   assign bus.cpu_data     = cpu_data_p1;
   assign bus.dbg_busy     = busy;
   assign bus.dbg_valid    = dbg_vld_p1;
   assign bus.dbg_data     = dbg_data_p1;
   assign bus.dbg_addr_out = dbg_addr_p1;
   assign bus.dbg_done     = dbg_done_p1;

`ifdef ROM_ARB_SUM_EN
   logic [DW-1:0] sum_p1;

   always_ff @(posedge clk) begin
      if (reset) begin
         sum_p1 <= '0;
      end else if (start_ok) begin
         sum_p1 <= '0;
      end else if (dbg_gnt) begin
         sum_p1 <= sum_p1 ^ bus.rom_data;
      end
   end

   assign bus.dbg_sum = sum_p1;
`else
   assign bus.dbg_sum = '0;
`endif

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed scenarios plus randomized traffic
// checked against a word-count/queue level reference model of the arbitration rules.
module tb_rom_port_arbiter;

   localparam int MAX_STALL = 4;
`ifdef ROM_ARB_SUM_EN
   localparam bit SUM_EN = 1'b1;
`else
   localparam bit SUM_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   rom_port_arbiter_if bus ();

   rom_port_arbiter #(.MAX_STALL(MAX_STALL)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   function automatic logic [34:0] rom_word(input logic [7:0] a);
      return {a[2:0], a, a ^ 8'hA5, ~a, a + 8'h3C};
   endfunction

   assign bus.rom_data = rom_word(bus.rom_addr);

   // Reference model: words left in the burst, next address, consecutive denials
   int          m_left = 0;
   bit          m_done = 1'b0;
   int          m_ptr  = 0;
   int          m_den  = 0;
   logic [34:0] m_sum  = '0;

   bit          ex_gnt;
   logic [7:0]  ex_rom_addr;
   bit          e_cpu_valid = 1'b0;
   logic [34:0] e_cpu_data  = '0;
   bit          e_busy      = 1'b0;
   bit          e_dbg_valid = 1'b0;
   logic [34:0] e_dbg_data  = '0;
   logic [7:0]  e_dbg_addr  = '0;
   bit          e_dbg_done  = 1'b0;
   logic [34:0] e_sum       = '0;

   logic        obs_gnt;
   logic [7:0]  obs_rom_addr;

   task automatic model_edge();
      bit dg;
      bit idle;
      dg          = (m_left > 0) && (!bus.cpu_req || (m_den == MAX_STALL));
      ex_gnt      = bus.cpu_req && !dg;
      ex_rom_addr = dg ? 8'(m_ptr) : bus.cpu_addr;
      if (reset) begin
         m_left = 0; m_done = 1'b0; m_ptr = 0; m_den = 0; m_sum = '0;
         e_cpu_valid = 1'b0; e_cpu_data = '0; e_busy = 1'b0; e_dbg_valid = 1'b0;
         e_dbg_data = '0; e_dbg_addr = '0; e_dbg_done = 1'b0; e_sum = '0;
         return;
      end
      idle        = (m_left == 0) && !m_done;
      e_cpu_valid = ex_gnt;
      if (ex_gnt) e_cpu_data = rom_word(bus.cpu_addr);
      e_dbg_valid = dg;
      e_dbg_done  = dg && (m_left == 1);
      if (dg) begin
         e_dbg_data = rom_word(8'(m_ptr));
         e_dbg_addr = 8'(m_ptr);
         m_sum      = m_sum ^ e_dbg_data;
         m_left     = m_left - 1;
         m_ptr      = (m_ptr + 1) % 256;
         m_den      = 0;
      end else if ((m_left > 0) && bus.cpu_req) begin
         m_den = m_den + 1;
      end
      m_done = e_dbg_done;
      if (idle && bus.dbg_start) begin
         m_left = (bus.dbg_len == 8'd0) ? 256 : int'(bus.dbg_len);
         m_ptr  = int'(bus.dbg_base);
         m_den  = 0;
         m_sum  = '0;
      end
      e_busy = (m_left > 0) || m_done;
      e_sum  = SUM_EN ? m_sum : '0;
   endtask

   // One clock: sample combinational outputs mid-cycle, advance model, return #1 after the edge
   task automatic cycle();
      @(negedge clk);
      obs_gnt      = bus.cpu_gnt;
      obs_rom_addr = bus.rom_addr;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.cpu_req = 1'b0; bus.cpu_addr = 8'h00; bus.dbg_start = 1'b0;
      bus.dbg_base = 8'h00; bus.dbg_len = 8'h00;
      reset = 1'b1;
      repeat (2) cycle();
      reset = 1'b0;
      bus.cpu_req = 1'b1; bus.cpu_addr = 8'h33;
      bus.dbg_start = 1'b1; bus.dbg_base = 8'h40; bus.dbg_len = 8'd6;
      cycle();
      bus.dbg_start = 1'b0;
      repeat (3) cycle();
      n_checks++;
      if (bus.dbg_busy !== 1'b1) begin
         n_fail++; $display("FAIL reset_pre_busy: got %b want 1", bus.dbg_busy);
      end
      reset = 1'b1;
      cycle();
      n_checks++;
      if ({bus.cpu_valid, bus.dbg_valid, bus.dbg_busy, bus.dbg_done} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 0000",
                            {bus.cpu_valid, bus.dbg_valid, bus.dbg_busy, bus.dbg_done});
      end
      n_checks++;
      if ({bus.cpu_data, bus.dbg_data, bus.dbg_addr_out, bus.dbg_sum} !== '0) begin
         n_fail++; $display("FAIL reset_data: got %h %h %h %h want 0", bus.cpu_data,
                            bus.dbg_data, bus.dbg_addr_out, bus.dbg_sum);
      end
      reset = 1'b0;
      cycle();
      n_checks++;
      if (obs_gnt !== 1'b1 || obs_rom_addr !== 8'h33 || bus.dbg_busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle: gnt %b addr %h busy %b want 1 33 0",
                            obs_gnt, obs_rom_addr, bus.dbg_busy);
      end
   endtask

   task automatic test_cpu_fetch();
      logic [7:0] addrs [3];
      addrs = '{8'd0, 8'd5, 8'd10};
      bus.cpu_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.cpu_addr = addrs[i];
         cycle();
         n_checks++;
         if (obs_gnt !== 1'b1) begin
            n_fail++; $display("FAIL cpu_fetch_gnt[%0d]: got %b want 1", i, obs_gnt);
         end
         n_checks++;
         if (bus.cpu_valid !== 1'b1 || bus.cpu_data !== rom_word(addrs[i])) begin
            n_fail++; $display("FAIL cpu_fetch_data[%0d]: got %b/%h want 1/%h", i,
                               bus.cpu_valid, bus.cpu_data, rom_word(addrs[i]));
         end
      end
      bus.cpu_req = 1'b0;
      cycle();
   endtask

   task automatic test_wrap_burst();
      logic [7:0] ea;
      bus.cpu_req = 1'b0;
      bus.dbg_base = 8'hFE; bus.dbg_len = 8'd3; bus.dbg_start = 1'b1;
      cycle();
      bus.dbg_start = 1'b0;
      n_checks++;
      if (bus.dbg_busy !== 1'b1) begin
         n_fail++; $display("FAIL wrap_busy: got %b want 1", bus.dbg_busy);
      end
      for (int k = 0; k < 3; k++) begin
         cycle();
         ea = 8'(254 + k);
         n_checks++;
         if (bus.dbg_valid !== 1'b1 || bus.dbg_addr_out !== ea || bus.dbg_data !== rom_word(ea)) begin
            n_fail++; $display("FAIL wrap_word[%0d]: got %b/%h/%h want 1/%h/%h", k,
                               bus.dbg_valid, bus.dbg_addr_out, bus.dbg_data, ea, rom_word(ea));
         end
         n_checks++;
         if (bus.dbg_done !== (k == 2)) begin
            n_fail++; $display("FAIL wrap_done[%0d]: got %b want %b", k, bus.dbg_done, (k == 2));
         end
      end
      cycle();
      n_checks++;
      if ({bus.dbg_busy, bus.dbg_valid, bus.dbg_done} !== 3'b000) begin
         n_fail++; $display("FAIL wrap_end: got %b want 000",
                            {bus.dbg_busy, bus.dbg_valid, bus.dbg_done});
      end
   endtask

   task automatic test_contention();
      int  seen;
      int  period;
      bit  exp_dbg;
      seen   = 0;
      period = MAX_STALL + 1;
      bus.cpu_req = 1'b1; bus.cpu_addr = 8'h77;
      bus.dbg_base = 8'h20; bus.dbg_len = 8'd2; bus.dbg_start = 1'b1;
      cycle();
      bus.dbg_start = 1'b0;
      for (int c = 1; c <= 2 * period + 1; c++) begin
         cycle();
         exp_dbg = ((c % period) == 0) && (c <= 2 * period);
         n_checks++;
         if (obs_gnt !== !exp_dbg) begin
            n_fail++; $display("FAIL contention_gnt[%0d]: got %b want %b", c, obs_gnt, !exp_dbg);
         end
         n_checks++;
         if (bus.dbg_valid !== exp_dbg || bus.dbg_done !== (exp_dbg && c == 2 * period)) begin
            n_fail++; $display("FAIL contention_dbg[%0d]: valid %b done %b want %b %b", c,
                               bus.dbg_valid, bus.dbg_done, exp_dbg, (exp_dbg && c == 2 * period));
         end
         if (exp_dbg) begin
            n_checks++;
            if (bus.dbg_addr_out !== 8'(8'h20 + seen)) begin
               n_fail++; $display("FAIL contention_addr[%0d]: got %h want %h", c,
                                  bus.dbg_addr_out, 8'(8'h20 + seen));
            end
            seen++;
         end else begin
            n_checks++;
            if (bus.cpu_valid !== 1'b1 || bus.cpu_data !== rom_word(8'h77)) begin
               n_fail++; $display("FAIL contention_cpu[%0d]: got %b/%h want 1/%h", c,
                                  bus.cpu_valid, bus.cpu_data, rom_word(8'h77));
            end
         end
      end
      n_checks++;
      if (bus.dbg_busy !== 1'b0) begin
         n_fail++; $display("FAIL contention_end_busy: got %b want 0", bus.dbg_busy);
      end
      bus.cpu_req = 1'b0;
      cycle();
   endtask

   task automatic test_len_zero();
      logic [7:0] base;
      int got;
      int dones;
      got = 0; dones = 0;
      base = 8'($urandom);
      bus.cpu_req = 1'b0;
      bus.dbg_base = base; bus.dbg_len = 8'd0; bus.dbg_start = 1'b1;
      cycle();
      bus.dbg_start = 1'b0;
      for (int c = 0; c < 262; c++) begin
         cycle();
         if (bus.dbg_valid === 1'b1) begin
            n_checks++;
            if (bus.dbg_addr_out !== 8'(base + got) || bus.dbg_data !== rom_word(8'(base + got))) begin
               n_fail++; $display("FAIL len0_word[%0d]: got %h/%h want %h", got,
                                  bus.dbg_addr_out, bus.dbg_data, 8'(base + got));
            end
            got++;
         end
         if (bus.dbg_done === 1'b1) begin
            dones++;
            n_checks++;
            if (got != 256) begin
               n_fail++; $display("FAIL len0_done_pos: done after %0d words want 256", got);
            end
         end
      end
      n_checks++;
      if (got != 256 || dones != 1 || bus.dbg_busy !== 1'b0) begin
         n_fail++; $display("FAIL len0_total: words %0d dones %0d busy %b want 256 1 0",
                            got, dones, bus.dbg_busy);
      end
   endtask

   task automatic test_start_ignored();
      int got;
      bit done_pulsed;
      got = 0; done_pulsed = 1'b0;
      bus.cpu_req = 1'b0;
      bus.dbg_base = 8'h10; bus.dbg_len = 8'd8; bus.dbg_start = 1'b1;
      cycle();
      for (int c = 0; c < 40; c++) begin
         bus.dbg_start = (c == 3) || (bus.dbg_done === 1'b1);
         if (bus.dbg_done === 1'b1) done_pulsed = 1'b1;
         bus.dbg_base = (c == 3) ? 8'h80 : 8'hC0;
         bus.dbg_len  = (c == 3) ? 8'd2 : 8'd1;
         cycle();
         bus.dbg_start = 1'b0;
         if (bus.dbg_valid === 1'b1) begin
            n_checks++;
            if (bus.dbg_addr_out !== 8'(8'h10 + got)) begin
               n_fail++; $display("FAIL ignore_addr[%0d]: got %h want %h", got,
                                  bus.dbg_addr_out, 8'(8'h10 + got));
            end
            got++;
         end
         if (done_pulsed) break;
      end
      n_checks++;
      if (!done_pulsed || got != 8 || bus.dbg_busy !== 1'b0) begin
         n_fail++; $display("FAIL ignore_len: done %b words %0d busy %b want 1 8 0",
                            done_pulsed, got, bus.dbg_busy);
      end
      cycle();
      n_checks++;
      if (bus.dbg_busy !== 1'b0 || bus.dbg_valid !== 1'b0) begin
         n_fail++; $display("FAIL ignore_in_done: busy %b valid %b want 0 0",
                            bus.dbg_busy, bus.dbg_valid);
      end
   endtask

   task automatic test_reset_mid_burst();
      int got;
      int late;
      got = 0; late = 0;
      bus.cpu_req = 1'b0;
      bus.dbg_base = 8'h50; bus.dbg_len = 8'd8; bus.dbg_start = 1'b1;
      cycle();
      bus.dbg_start = 1'b0;
      for (int c = 0; c < 20 && got < 3; c++) begin
         cycle();
         if (bus.dbg_valid === 1'b1) got++;
      end
      n_checks++;
      if (got != 3) begin
         n_fail++; $display("FAIL abort_reach: got %0d words want 3", got);
      end
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      n_checks++;
      if (bus.dbg_busy !== 1'b0 || bus.dbg_valid !== 1'b0 || bus.dbg_done !== 1'b0) begin
         n_fail++; $display("FAIL abort_state: busy %b valid %b done %b want 0 0 0",
                            bus.dbg_busy, bus.dbg_valid, bus.dbg_done);
      end
      repeat (12) begin
         cycle();
         if (bus.dbg_done === 1'b1 || bus.dbg_valid === 1'b1 || bus.dbg_busy === 1'b1) late++;
      end
      n_checks++;
      if (late != 0) begin
         n_fail++; $display("FAIL abort_no_done: %0d active cycles want 0", late);
      end
   endtask

   task automatic test_checksum();
      logic [34:0] exp_sum;
      bit seen;
      seen = 1'b0;
      exp_sum = SUM_EN ? (rom_word(8'd0) ^ rom_word(8'd1) ^ rom_word(8'd2)) : 35'd0;
      bus.cpu_req = 1'b0;
      bus.dbg_base = 8'd0; bus.dbg_len = 8'd3; bus.dbg_start = 1'b1;
      cycle();
      bus.dbg_start = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         cycle();
         if (bus.dbg_done === 1'b1) begin
            seen = 1'b1;
            n_checks++;
            if (bus.dbg_sum !== exp_sum) begin
               n_fail++; $display("FAIL checksum_done: got %h want %h", bus.dbg_sum, exp_sum);
            end
            cycle();
            n_checks++;
            if (bus.dbg_sum !== exp_sum) begin
               n_fail++; $display("FAIL checksum_hold: got %h want %h", bus.dbg_sum, exp_sum);
            end
         end
      end
      n_checks++;
      if (!seen) begin
         n_fail++; $display("FAIL checksum_timeout: dbg_done %b want 1", seen);
      end
   endtask

   task automatic test_random();
      logic [116:0] obs_v;
      logic [116:0] exp_v;
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         if (!bus.cpu_req || obs_gnt) begin
            bus.cpu_req  = ($urandom_range(0, 3) != 0);
            bus.cpu_addr = 8'($urandom);
         end
         bus.dbg_start = ($urandom_range(0, 9) == 0);
         bus.dbg_base  = 8'($urandom);
         bus.dbg_len   = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
         cycle();
         n_checks++;
         if (obs_gnt !== ex_gnt || obs_rom_addr !== ex_rom_addr) begin
            n_fail++; $display("FAIL random_comb[%0d]: gnt %b addr %h want %b %h", c,
                               obs_gnt, obs_rom_addr, ex_gnt, ex_rom_addr);
         end
         obs_v = {bus.cpu_valid, bus.cpu_data, bus.dbg_busy, bus.dbg_valid, bus.dbg_data,
                  bus.dbg_addr_out, bus.dbg_done, bus.dbg_sum};
         exp_v = {e_cpu_valid, e_cpu_data, e_busy, e_dbg_valid, e_dbg_data,
                  e_dbg_addr, e_dbg_done, e_sum};
         n_checks++;
         if (obs_v !== exp_v) begin
            n_fail++; $display("FAIL random_regs[%0d]: got %h want %h", c, obs_v, exp_v);
         end
      end
      reset = 1'b0;
      bus.dbg_start = 1'b0;
      bus.cpu_req = 1'b0;
      cycle();
   endtask

   initial begin
      bus.cpu_req = 1'b0; bus.cpu_addr = 8'h00; bus.dbg_start = 1'b0;
      bus.dbg_base = 8'h00; bus.dbg_len = 8'h00;
      test_reset();
      test_cpu_fetch();
      test_wrap_burst();
      test_contention();
      test_len_zero();
      test_start_ignored();
      test_reset_mid_burst();
      test_checksum();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
